divider_control: RTL and testbench
==================================

# divider_control

Sequencing FSM for the sequential 32-bit restoring divider. It sits directly upstream of the remainder register and drives that register's load, shift-left and shift-right controls, its ALU subtract select and its Ready qualifier. It accepts a start request, runs the fixed load → initial shift → N subtract-shift iterations → final right-shift sequence, then holds Ready until the next request.

## Interface
- ITER, 32, number of subtract/shift iterations; equals the operand width.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > ITER.

- clk  input  1  system clock; the FSM updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Run  input  1  start request; sampled on the rising clk edge in IDLE or DONE.
- Divisor_zero  input  1  divisor-is-zero flag from the divisor register; used only with the zero-check feature.
- W_ctrl  output  1  remainder/divisor write enable; high in LOAD only.
- Load  output  1  datapath load strobe, wired to the remainder register's load input; high in LOAD only.
- SLL_ctrl  output  1  remainder shift-left; high in SHIFT0 and ITER.
- SRL_ctrl  output  1  remainder upper-half shift-right; high in FIX only.
- ALU_sub  output  1  ALU subtract select; high in ITER only.
- Ready  output  1  result valid; high in DONE only.
- Busy  output  1  high in LOAD, SHIFT0, ITER and FIX.
- Iter_cnt  output  CNT_W  completed-iteration count; 0 outside ITER.
- Div_err  output  1  divide-by-zero flag; 0 unless the zero-check feature is compiled in.

## Operation
- States: IDLE, LOAD, SHIFT0, ITER, FIX, DONE. All outputs are registered Moore decodes of the state.
- IDLE: all outputs 0. If Run = 1, go to LOAD.
- LOAD: W_ctrl = 1 and Load = 1. Clear Iter_cnt. Clear Div_err. Go to SHIFT0.
- SHIFT0: SLL_ctrl = 1. Go to ITER.
- ITER: SLL_ctrl = 1 and ALU_sub = 1. Iter_cnt increments every cycle. When Iter_cnt = ITER-1 at the edge, go to FIX and reset Iter_cnt to 0.
- FIX: SRL_ctrl = 1. Go to DONE.
- DONE: Ready = 1, and it holds. If Run = 1, go to LOAD (back-to-back operation). Otherwise stay in DONE.
- Run is ignored in LOAD, SHIFT0, ITER and FIX. The controller has no abort path.
- The control outputs are one-hot among W_ctrl, SLL_ctrl and SRL_ctrl. Ready is never high together with any control output.
- Reset = 0 forces IDLE immediately, at any time including mid-operation. On reset every output is 0 and Iter_cnt = 0. The datapath contents after an aborted run are undefined.

## Timing
- Outputs change only on the rising clk edge. The datapath samples them on the falling edge, which gives a half-cycle setup window.
- Edge 0 is the edge that samples Run = 1. The state sequence is then:
  - after edge 0: LOAD
  - after edge 1: SHIFT0
  - after edges 2 to ITER+1: ITER (ITER cycles)
  - after edge ITER+2: FIX
  - after edge ITER+3: DONE
- For ITER = 32, Ready rises 35 edges after edge 0. SLL_ctrl is high for 33 consecutive cycles.
- Ready falls on the edge after a new Run is accepted in DONE. That same edge moves the FSM to LOAD.
- Run pulse width: one cycle is sufficient. Holding Run high in DONE starts a new run every ITER+4 cycles.
- On Reset deassertion, the first rising edge may already sample Run.

## Configuration
- DIV_ZERO_CHECK_EN
  - Defined: in LOAD, if Divisor_zero = 1, the next state is DONE instead of SHIFT0, with Div_err = 1. Ready rises at edge 1 after acceptance and no shift controls are issued. Div_err holds until the next accepted Run reaches LOAD, or until reset.
  - Undefined: Divisor_zero is ignored, Div_err is tied 0, and every run takes the full ITER+4 cycles.

## Test plan
- Reset = 0 mid-ITER with Iter_cnt = 17 → all outputs 0 immediately (asynchronously) and the state is IDLE. After release, a Run completes a normal 35-edge sequence.
- Run pulse from IDLE with ITER = 32 → W_ctrl and Load high 1 cycle, SLL_ctrl 33 cycles, ALU_sub 32 cycles, SRL_ctrl 1 cycle, Ready high at edge 35. Iter_cnt counts 1…31 then returns to 0.
- Run asserted during ITER and FIX → ignored, no timing change, Ready still at edge 35.
- Run held high continuously → a LOAD cycle follows every DONE cycle. Ready is high for exactly 1 cycle per 36-cycle period.
- With DIV_ZERO_CHECK_EN defined, Divisor_zero = 1 → Ready and Div_err both 1 after edge 1, no SLL_ctrl/SRL_ctrl. Next Run with Divisor_zero = 0 → Div_err clears in LOAD and the run completes normally.
- Datapath integration: dividend 100, divisor 7 → at Ready, quotient = 14 and remainder = 2. Dividend 0xFFFFFFFF, divisor 1 → quotient 0xFFFFFFFF, remainder 0.

Source files
------------

// File: rtl/divider_control.sv
// divider_control: sequencing FSM for a 32-bit restoring divider (load, shift, ITER subtract-shifts, fix-up).
// Optional divide-by-zero short-circuit enabled by defining DIV_ZERO_CHECK_EN.
module divider_control #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Divisor_zero,
  output logic             W_ctrl,
  output logic             Load,
  output logic             SLL_ctrl,
  output logic             SRL_ctrl,
  output logic             ALU_sub,
  output logic             Ready,
  output logic             Busy,
  output logic [CNT_W-1:0] Iter_cnt,
  output logic             Div_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT0, S_ITER, S_FIX, S_DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic zero;
`ifdef DIV_ZERO_CHECK_EN
  logic err, err_n;
  assign zero = Divisor_zero;
  // Cleared on entry to LOAD, set on the LOAD edge that short-circuits to DONE.
  assign err_n = (state == S_LOAD) ? zero : (state_n == S_LOAD) ? 1'b0 : err;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) err <= 1'b0;
    else err <= err_n;
  assign Div_err = err;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = Divisor_zero;
  assign zero = 1'b0;
  assign Div_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    unique case (state)
      S_IDLE:   state_n = Run ? S_LOAD : S_IDLE;
      S_LOAD:   state_n = zero ? S_DONE : S_SHIFT0;
      S_SHIFT0: state_n = S_ITER;
      S_ITER: begin
        state_n = (cnt == CNT_W'(ITER - 1)) ? S_FIX : S_ITER;
        cnt_n   = (cnt == CNT_W'(ITER - 1)) ? '0 : cnt + 1'b1;
      end
      S_FIX:    state_n = S_DONE;
      S_DONE:   state_n = Run ? S_LOAD : S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end
  assign W_ctrl   = state == S_LOAD;
  assign Load     = state == S_LOAD;
  assign SLL_ctrl = (state == S_SHIFT0) || (state == S_ITER);
  assign SRL_ctrl = state == S_FIX;
  assign ALU_sub  = state == S_ITER;
  assign Ready    = state == S_DONE;
  assign Busy     = (state == S_LOAD) || (state == S_SHIFT0) || (state == S_ITER) || (state == S_FIX);
  assign Iter_cnt = cnt;
endmodule

// File: tb/tb_divider_control.sv
// tb_divider_control: directed self-checking bench for divider_control with a behavioural restoring datapath.
module tb_divider_control;
  logic clk = 0, Reset = 1, Run = 0, Divisor_zero = 0;
  logic W_ctrl, Load, SLL_ctrl, SRL_ctrl, ALU_sub, Ready, Busy, Div_err;
  logic [5:0] Iter_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [13:0] obs;
  logic [64:0] rem;
  logic [31:0] dvd, dvs;
  logic [32:0] dif;
  logic ge;

  divider_control dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Divisor_zero(Divisor_zero),
    .W_ctrl(W_ctrl), .Load(Load), .SLL_ctrl(SLL_ctrl), .SRL_ctrl(SRL_ctrl),
    .ALU_sub(ALU_sub), .Ready(Ready), .Busy(Busy), .Iter_cnt(Iter_cnt), .Div_err(Div_err)
  );

  always #5 clk = ~clk;

  assign obs = {W_ctrl, Load, SLL_ctrl, SRL_ctrl, ALU_sub, Ready, Busy, Div_err, Iter_cnt};

  // Restoring datapath consuming the controls on the falling edge.
  assign dif = rem[64:32] - {1'b0, dvs};
  assign ge  = rem[64:32] >= {1'b0, dvs};
  always @(negedge clk)
    if (Load) rem <= {33'd0, dvd};
    else if (ALU_sub) rem <= ge ? {dif[31:0], rem[31:0], 1'b1} : {rem[63:0], 1'b0};
    else if (SLL_ctrl) rem <= {rem[63:0], 1'b0};
    else if (SRL_ctrl) rem <= {1'b0, rem[64:33], rem[31:0]};

  // Expected output vector after edge e (edge 0 samples Run), negative e means idle.
  function automatic logic [13:0] exp_vec(int e);
    if (e < 0) return 14'd0;
    if (e == 0) return {8'b1100_0010, 6'd0};
    if (e == 1) return {8'b0010_0010, 6'd0};
    if (e <= 33) return {8'b0010_1010, 6'(e - 2)};
    if (e == 34) return {8'b0001_0010, 6'd0};
    return {8'b0000_0100, 6'd0};
  endfunction

  task automatic test_reset;
    #2 Reset = 0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL reset_async got %h want %h", obs, 14'd0); end
    Run = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL reset_hold got %h want %h", obs, 14'd0); end
    Run = 0;
    Reset = 1;
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(-1)) begin n_bad++; $display("FAIL idle got %h want %h", obs, exp_vec(-1)); end
  endtask

  task automatic test_normal;
    int sll = 0, alu = 0, srl = 0, ld = 0;
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 37; e++) begin
      @(negedge clk);
      if (e == 0) Run = 0;
      n_cmp++;
      if (obs !== exp_vec(e)) begin n_bad++; $display("FAIL normal e=%0d got %h want %h", e, obs, exp_vec(e)); end
      sll += int'(SLL_ctrl); alu += int'(ALU_sub); srl += int'(SRL_ctrl); ld += int'(Load);
    end
    n_cmp++;
    if (sll != 33 || alu != 32 || srl != 1 || ld != 1) begin
      n_bad++; $display("FAIL normal_counts got sll=%0d alu=%0d srl=%0d load=%0d want 33/32/1/1", sll, alu, srl, ld);
    end
  endtask

  task automatic test_run_ignored;
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 37; e++) begin
      @(negedge clk);
      Run = (e >= 9 && e <= 34);
      n_cmp++;
      if (obs !== exp_vec(e)) begin n_bad++; $display("FAIL run_ignored e=%0d got %h want %h", e, obs, exp_vec(e)); end
    end
  endtask

  task automatic test_back_to_back;
    int rdy = 0;
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 71; e++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(e % 36)) begin n_bad++; $display("FAIL b2b e=%0d got %h want %h", e, obs, exp_vec(e % 36)); end
      rdy += int'(Ready);
    end
    Run = 0;
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(35) || rdy != 2) begin
      n_bad++; $display("FAIL b2b_end got %h ready_cycles=%0d want %h ready_cycles=2", obs, rdy, exp_vec(35));
    end
  endtask

  task automatic test_div_zero;
`ifdef DIV_ZERO_CHECK_EN
    logic [13:0] ev;
    Divisor_zero = 1;
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 2; e++) begin
      @(negedge clk);
      if (e == 0) Run = 0;
      ev = (e == 0) ? exp_vec(0) : {8'b0000_0101, 6'd0};
      n_cmp++;
      if (obs !== ev) begin n_bad++; $display("FAIL div_zero e=%0d got %h want %h", e, obs, ev); end
    end
    Divisor_zero = 0;
`else
    Divisor_zero = 1;
`endif
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 35; e++) begin
      @(negedge clk);
      if (e == 0) Run = 0;
      n_cmp++;
      if (obs !== exp_vec(e)) begin n_bad++; $display("FAIL div_zero_next e=%0d got %h want %h", e, obs, exp_vec(e)); end
    end
    Divisor_zero = 0;
  endtask

  task automatic test_datapath(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int i;
    dvd = a;
    dvs = b;
    @(negedge clk) Run = 1;
    @(negedge clk) Run = 0;
    for (i = 0; i < 100 && !Ready; i++) @(negedge clk);
    n_cmp++;
    if (!Ready) begin n_bad++; $display("FAIL datapath_timeout %0d/%0d no Ready after %0d cycles", a, b, i); end
    n_cmp++;
    if (rem[31:0] !== q || rem[64:32] !== {1'b0, r}) begin
      n_bad++; $display("FAIL datapath %0d/%0d got q=%h r=%h want q=%h r=%h", a, b, rem[31:0], rem[64:32], q, r);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk) Run = 1;
    for (int e = 0; e <= 19; e++) begin
      @(negedge clk);
      if (e == 0) Run = 0;
    end
    n_cmp++;
    if (Iter_cnt !== 6'd17) begin n_bad++; $display("FAIL mid_cnt got %0d want 17", Iter_cnt); end
    #1 Reset = 0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL mid_reset_async got %h want %h", obs, 14'd0); end
    @(negedge clk);
    n_cmp++;
    if (obs !== 14'd0) begin n_bad++; $display("FAIL mid_reset_hold got %h want %h", obs, 14'd0); end
    Reset = 1;
    Run = 1;
    for (int e = 0; e <= 36; e++) begin
      @(negedge clk);
      if (e == 0) Run = 0;
      n_cmp++;
      if (obs !== exp_vec(e)) begin n_bad++; $display("FAIL after_reset e=%0d got %h want %h", e, obs, exp_vec(e)); end
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_run_ignored;
    test_back_to_back;
    test_div_zero;
    test_datapath(32'd100, 32'd7, 32'd14, 32'd2);
    test_datapath(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
